pixel_write_arbiter: RTL and testbench
======================================

# pixel_write_arbiter

Shares the single pixel write port of the `colorshield` driver between several independent requesters, such as a button cursor, a pattern generator and a clear engine. Each request is latched, presented to the shield, held until the shield's `ready` window accepts it, and acknowledged to the owner. The block sits between the application logic and `colorshield`, driving its `write_en`, `pixel_addr` and `pixel_value` inputs and observing its `ready` output.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ADDR_W`, default 6: pixel address width, `{x[2:0], y[2:0]}`.
- `DATA_W`, default 24: pixel colour width.
- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: request per requester, level.
- `req_addr`  in  N_REQ*ADDR_W: packed addresses; requester i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `req_value`  in  N_REQ*DATA_W: packed colours; same packing as `req_addr`.
- `ack`  out  N_REQ: one-cycle pulse to the owner after its write is accepted.
- `shield_ready`  in  1: `colorshield.ready`.
- `write_en`  out  1: to `colorshield.write_en`.
- `pixel_addr`  out  ADDR_W: to the shield.
- `pixel_value`  out  DATA_W: to the shield.
- `busy`  out  1: high in PRESENT and ACK.
- `owner`  out  $clog2(N_REQ): index of the current or last granted requester.

## Operation
- State machine with three states: IDLE, PRESENT, ACK.
- **IDLE**
  - If any `req` bit is high, pick a winner with round-robin priority. The search starts at `rr_ptr` and wraps from `N_REQ-1` to 0.
  - Register the winner's addr and value into `pixel_addr` and `pixel_value`.
  - Set `write_en=1` and `owner=winner`, then go to PRESENT.
  - If no `req` bit is high, stay in IDLE with `write_en=0`.
- **PRESENT**
  - Hold all outputs stable.
  - A cycle with `shield_ready=1` is the acceptance cycle. On the next edge: `write_en<=0`, `ack[owner]<=1`, `rr_ptr<=owner+1` (mod N_REQ), go to ACK.
  - If `shield_ready=0`, wait here indefinitely.
- **ACK**
  - `ack[owner]` is high for exactly this one cycle; `write_en=0`.
  - Go to IDLE unconditionally.
- Requester contract:
  - Hold `req`, addr and value stable until `ack` is seen.
  - Drop `req`, or change the data for a new write, in the cycle after `ack`.
- Address and value are sampled only in IDLE. Changes by the requester during PRESENT are ignored.
- A requester that drops `req` during PRESENT still gets its latched write performed and still receives `ack`. There is no cancel.
- Throughput: at most one write per 3 cycles when `shield_ready` is continuously high.
- Values pass through unmodified; no arithmetic is applied to pixel data. `rr_ptr` wraps modulo `N_REQ`, including non-power-of-two `N_REQ`.

## Timing
- Reset values: state=IDLE, `write_en=0`, `pixel_addr=0`, `pixel_value=0`, `ack=0`, `busy=0`, `owner=0`, `rr_ptr=0`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from `req` rising in IDLE to `write_en` high: 1 cycle.
- Latency from the acceptance cycle to `ack`: 1 cycle.
- Reset asserted mid-operation: the in-flight write is abandoned, no `ack` is issued, and all outputs return to reset values immediately (asynchronously).
- Several requests rising in the same cycle: exactly one grant. The others wait; no request is lost.
- `shield_ready` already high when PRESENT is entered: acceptance happens in the first PRESENT cycle.

## Configuration
- `PIXARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest asserted index always wins, and `rr_ptr` is unused and stays 0.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared package `colorshield_pkg` holds:
  - `PIX_ADDR_W=6` and `PIX_DATA_W=24`;
  - the `arb_state_t` enum (IDLE, PRESENT, ACK).
- Sub-module `rr_picker`: combinational, taking `req` and `rr_ptr` and producing `valid` and the winner index. It contains the `PIXARB_FIXED_PRIO_EN` switch.

## Test plan
- **Single request:** reset, then requester 2 holds addr=0x24, value=0xFF0000, with `shield_ready` high.
  - Required response: `write_en` high 1 cycle after `req`, with `pixel_addr=0x24`.
  - `ack[2]` pulses exactly one cycle later; `busy` falls after ACK.
- **Stall:** `shield_ready` low for 50 cycles during PRESENT, then high.
  - Required response: outputs stay stable and `ack` stays 0 throughout the stall.
  - The `ack` pulse follows the first ready cycle.
- **Contention:** all 4 requesters hold `req` continuously and re-arm after each `ack`.
  - Required response, round-robin: grant order 0,1,2,3,0.
  - Required response, with `PIXARB_FIXED_PRIO_EN` defined: requester 0 always wins.
- **Reset mid-operation:** assert `rst_n` low during PRESENT.
  - Required response: `write_en=0` with no `ack`, and all outputs at reset values.
  - After release with `req` still high, the write is re-issued.
- **Late data change:** requester 1 changes addr from 0x00 to 0x3F during PRESENT.
  - Required response: `pixel_addr` stays 0x00 until `ack`.
- **Non-power-of-two width:** `N_REQ=3`, requesters 0 and 2 active.
  - Required response: `rr_ptr` wraps from 2 to 0 and grants alternate 0,2,0,2.

Source files
------------

// File: rtl/colorshield_pkg.sv
// Shared definitions for the colorshield pixel path: pixel bus widths and
// the write arbiter state encoding.
package colorshield_pkg;

    localparam int PIX_ADDR_W = 6;
    localparam int PIX_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for pixel_write_arbiter. Round-robin from
// rr_ptr by default; PIXARB_FIXED_PRIO_EN selects lowest-index-wins instead.
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    input  logic [$clog2(N_REQ)-1:0] owner,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic [$clog2(N_REQ)-1:0] next_ptr
);

    localparam int PTR_W = $clog2(N_REQ);

`ifdef PIXARB_FIXED_PRIO_EN
    logic unused_ptr_inputs;
    assign unused_ptr_inputs = ^{rr_ptr, owner};

    always_comb begin
        valid    = |req;
        winner   = '0;
        next_ptr = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = PTR_W'(i);
        end
    end
`else
    int idx;

    // Walk offsets high to low so the smallest offset from rr_ptr wins last.
    always_comb begin
        valid    = |req;
        winner   = '0;
        idx      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) winner = PTR_W'(idx);
        end
        next_ptr = (int'(owner) == N_REQ - 1) ? '0 : owner + PTR_W'(1);
    end
`endif

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the colorshield pixel write port among N_REQ requesters; one latched
// write at a time, held until shield_ready, then acked. See PIXARB_FIXED_PRIO_EN.
module pixel_write_arbiter
    import colorshield_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_value,
    output logic [N_REQ-1:0]          ack,
    input  logic                      shield_ready,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         pixel_addr,
    output logic [DATA_W-1:0]         pixel_value,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              we_q, we_d;
    logic [N_REQ-1:0]  ack_q, ack_d;

    logic              pick_valid;
    logic [PTR_W-1:0]  pick_win;
    logic [PTR_W-1:0]  ptr_after;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .owner    (owner_q),
        .valid    (pick_valid),
        .winner   (pick_win),
        .next_ptr (ptr_after)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            value_q  <= '0;
            we_q     <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            value_q  <= value_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        value_d  = value_q;
        we_d     = we_q;
        ack_d    = '0;
        case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (pick_valid) begin
                    addr_d  = req_addr[int'(pick_win)*ADDR_W +: ADDR_W];
                    value_d = req_value[int'(pick_win)*DATA_W +: DATA_W];
                    owner_d = pick_win;
                    we_d    = 1'b1;
                    state_d = PRESENT;
                end
            end
            // Latched request is held here; requester-side changes are ignored.
            PRESENT: begin
                if (shield_ready) begin
                    we_d           = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    rr_ptr_d       = ptr_after;
                    state_d        = ACK;
                end
            end
            ACK: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign write_en    = we_q;
    assign pixel_addr  = addr_q;
    assign pixel_value = value_q;
    assign ack         = ack_q;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboarded bench for pixel_write_arbiter (N_REQ=4) plus an N_REQ=3 instance.
module tb_pixel_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 24;

    typedef struct {
        int          owner;
        logic [5:0]  addr;
        logic [23:0] value;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    ack;
    logic            shield_ready;
    logic            write_en;
    logic [AW-1:0]   pixel_addr;
    logic [DW-1:0]   pixel_value;
    logic            busy;
    logic [1:0]      owner;

    logic [2:0]      req3;
    logic [3*AW-1:0] req3_addr;
    logic [3*DW-1:0] req3_value;
    logic [2:0]      ack3;
    logic            we3;
    logic [AW-1:0]   pa3;
    logic [DW-1:0]   pv3;
    logic            busy3;
    logic [1:0]      owner3;

    pixel_write_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_value(req_value), .ack(ack), .shield_ready(shield_ready),
        .write_en(write_en), .pixel_addr(pixel_addr), .pixel_value(pixel_value),
        .busy(busy), .owner(owner)
    );

    pixel_write_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(req3_addr),
        .req_value(req3_value), .ack(ack3), .shield_ready(shield_ready),
        .write_en(we3), .pixel_addr(pa3), .pixel_value(pv3),
        .busy(busy3), .owner(owner3)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [23:0] v);
        req_addr[i*AW +: AW]  = a;
        req_value[i*DW +: DW] = v;
    endtask

    task automatic push(input int o, input logic [5:0] a, input logic [23:0] v);
        exp_t e;
        e.owner = o;
        e.addr  = a;
        e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (ack != '0) begin
                for (int k = 0; k < N; k++) if (ack[k]) idx = k;
                return;
            end
        end
        check("ack_timeout", 0, 1);
    endtask

    function automatic logic [5:0] c_addr(input int i, input int g);
        return 6'(i * 8 + g);
    endfunction

    function automatic logic [23:0] c_val(input int i, input int g);
        return 24'(32'h00A000 * (i + 1) + g);
    endfunction

    // Scoreboard: every ack pops the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && ack != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 64'(ack), 0);
            end else begin
                exp_t e;
                logic [N-1:0] one_hot;
                e = exp_q.pop_front();
                one_hot = '0;
                one_hot[e.owner] = 1'b1;
                check("sb_owner", 64'(owner), 64'(e.owner));
                check("sb_ack", 64'(ack), 64'(one_hot));
                check("sb_addr", 64'(pixel_addr), 64'(e.addr));
                check("sb_value", 64'(pixel_value), 64'(e.value));
                check("sb_we_low", 64'(write_en), 0);
            end
        end
    end

    int order[5];
    int gen[N];
    int order3[4];
    int idx;

    initial begin
        rst_n = 1'b0; req = '0; req_addr = '0; req_value = '0; shield_ready = 1'b0;
        req3 = '0; req3_addr = '0; req3_value = '0;
        #3;
        check("rst_we", 64'(write_en), 0);
        check("rst_addr", 64'(pixel_addr), 0);
        check("rst_value", 64'(pixel_value), 0);
        check("rst_ack", 64'(ack), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_owner", 64'(owner), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single request, ready already high
        shield_ready = 1'b1;
        set_req(2, 6'h24, 24'hFF0000);
        req[2] = 1'b1;
        push(2, 6'h24, 24'hFF0000);
        tick();
        check("single_we", 64'(write_en), 1);
        check("single_addr", 64'(pixel_addr), 64'h24);
        check("single_value", 64'(pixel_value), 64'hFF0000);
        check("single_owner", 64'(owner), 2);
        check("single_busy", 64'(busy), 1);
        check("single_ack_early", 64'(ack), 0);
        tick();
        check("single_ack", 64'(ack), 64'h4);
        check("single_busy_ack", 64'(busy), 1);
        req[2] = 1'b0;
        tick();
        check("single_ack_gone", 64'(ack), 0);
        check("single_busy_fall", 64'(busy), 0);

        // Stall with late data change and dropped req
        shield_ready = 1'b0;
        set_req(1, 6'h00, 24'h00FF00);
        req[1] = 1'b1;
        push(1, 6'h00, 24'h00FF00);
        tick();
        check("stall_we", 64'(write_en), 1);
        set_req(1, 6'h3F, 24'h0000FF);
        req[1] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("stall_we_hold", 64'(write_en), 1);
            check("stall_addr_hold", 64'(pixel_addr), 0);
            check("stall_value_hold", 64'(pixel_value), 64'h00FF00);
            check("stall_no_ack", 64'(ack), 0);
        end
        shield_ready = 1'b1;
        tick();
        check("stall_ack", 64'(ack), 64'h2);
        check("stall_addr_at_ack", 64'(pixel_addr), 0);
        tick();
        check("stall_ack_pulse", 64'(ack), 0);

        // Reset during PRESENT
        shield_ready = 1'b0;
        set_req(3, 6'h15, 24'h123456);
        req[3] = 1'b1;
        push(3, 6'h15, 24'h123456);
        tick();
        check("rmid_we", 64'(write_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_we0", 64'(write_en), 0);
        check("rmid_ack0", 64'(ack), 0);
        check("rmid_busy0", 64'(busy), 0);
        check("rmid_owner0", 64'(owner), 0);
        check("rmid_addr0", 64'(pixel_addr), 0);
        check("rmid_value0", 64'(pixel_value), 0);
        tick(); tick();
        check("rmid_ack_held", 64'(ack), 0);
        rst_n = 1'b1;
        shield_ready = 1'b1;
        tick();
        check("rmid_reissue_we", 64'(write_en), 1);
        check("rmid_reissue_owner", 64'(owner), 3);
        check("rmid_reissue_addr", 64'(pixel_addr), 64'h15);
        tick();
        check("rmid_ack", 64'(ack), 64'h8);
        req[3] = 1'b0;
        tick();

        // Contention: all four requesters continuously, re-arming after ack
`ifdef PIXARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < N; i++) gen[i] = 0;
        for (int k = 0; k < 5; k++) begin
            push(order[k], c_addr(order[k], gen[order[k]]), c_val(order[k], gen[order[k]]));
            gen[order[k]]++;
        end
        for (int i = 0; i < N; i++) begin
            gen[i] = 0;
            set_req(i, c_addr(i, 0), c_val(i, 0));
        end
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(20, idx);
            check("cont_grant", 64'(idx), 64'(order[k]));
            if (idx >= 0) begin
                gen[idx]++;
                set_req(idx, c_addr(idx, gen[idx]), c_val(idx, gen[idx]));
            end
        end
        req = '0;
        tick(); tick();

        // Non-power-of-two instance: requesters 0 and 2
`ifdef PIXARB_FIXED_PRIO_EN
        order3 = '{0, 0, 0, 0};
`else
        order3 = '{0, 2, 0, 2};
`endif
        req3_addr  = {6'h2A, 6'h00, 6'h11};
        req3_value = {24'hC0FFEE, 24'h0, 24'hBEEF01};
        req3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            int got;
            got = -1;
            for (int c = 0; c < 20 && got < 0; c++) begin
                tick();
                if (ack3 != '0) got = ack3[2] ? 2 : (ack3[1] ? 1 : 0);
            end
            if (got < 0) check("n3_timeout", 0, 1);
            check("n3_grant", 64'(got), 64'(order3[k]));
            check("n3_addr", 64'(pa3), (order3[k] == 2) ? 64'h2A : 64'h11);
        end
        req3 = '0;
        tick(); tick();

        check("sb_drain", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
